vga_timing_gen: RTL

Free-running 640x480@60 Hz raster timing generator that produces the `DrawX`/`DrawY`/`blank` stream consumed directly by every sprite ROM/palette drawing stage, plus `hs`/`vs` for the VGA connector. It runs on the 25 MHz pixel clock `vga_clk`. It also emits per-line and per-frame strobes and a frame counter, so sprite stages can step animation frames without a separate counter. Every output is registered and mutually aligned on the same `vga_clk` edge.

---
 rtl/vga_pkg.sv | 25 ++
 rtl/vga_mod_counter.sv | 39 +++
 rtl/vga_timing_gen.sv | 96 +++++++++
 3 files changed

// File: rtl/vga_pkg.sv
`default_nettype none
// ==========================================================================
// vga_pkg: default 640x480@60 timing and the draw-coordinate type
// Revision 1.0
// ==========================================================================
package vga_pkg;

  localparam int DRAW_W = 10;

  localparam int H_VISIBLE = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

  localparam int V_VISIBLE = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;
  localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  typedef logic [DRAW_W-1:0] draw_coord_t;

endpackage
`default_nettype wire

// File: rtl/vga_mod_counter.sv
`default_nettype none
// ==========================================================================
// vga_mod_counter: modulo-MOD counter with enable, wrap flag and look-ahead
// Revision 1.0
// ==========================================================================
module vga_mod_counter
  import vga_pkg::*;
#(
  parameter int MOD = H_TOTAL,
  parameter int W   = DRAW_W
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en,
  output logic [W-1:0] count,
  output logic [W-1:0] count_next,
  output logic         wrap
);

  always_comb begin
    wrap       = en && (count == W'(MOD - 1));
    count_next = count;
    if (wrap) begin
      count_next = '0;
    end else if (en) begin
      count_next = count + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count <= '0;
    end else begin
      count <= count_next;
    end
  end

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ==========================================================================
// vga_timing_gen: free-running raster timing with syncs, strobes, frame count
// Revision 1.0
// ==========================================================================
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_VISIBLE = vga_pkg::H_VISIBLE,
  parameter int H_FRONT   = vga_pkg::H_FRONT,
  parameter int H_SYNC    = vga_pkg::H_SYNC,
  parameter int H_BACK    = vga_pkg::H_BACK,
  parameter int V_VISIBLE = vga_pkg::V_VISIBLE,
  parameter int V_FRONT   = vga_pkg::V_FRONT,
  parameter int V_SYNC    = vga_pkg::V_SYNC,
  parameter int V_BACK    = vga_pkg::V_BACK,
  parameter int FC_W      = 16
) (
  input  logic            vga_clk,
  input  logic            reset_n,
  output draw_coord_t     DrawX,
  output draw_coord_t     DrawY,
  output logic            blank,
  output logic            hs,
  output logic            vs,
  output logic            line_start,
  output logic            frame_start,
  output logic [FC_W-1:0] frame_count
);

  localparam int H_TOT    = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOT    = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_BEGIN = H_VISIBLE + H_FRONT;
  localparam int HS_END   = H_VISIBLE + H_FRONT + H_SYNC;
  localparam int VS_BEGIN = V_VISIBLE + V_FRONT;
  localparam int VS_END   = V_VISIBLE + V_FRONT + V_SYNC;

  generate
    if (H_TOT > (1 << DRAW_W) || V_TOT > (1 << DRAW_W)) begin : g_bad_totals
      $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed the 10-bit counter range");
    end
  endgenerate

  draw_coord_t hc_next;
  draw_coord_t vc_next;
  logic        h_wrap;
  logic        v_wrap;

  // The counter registers are the DrawX/DrawY output registers.
  vga_mod_counter #(
    .MOD (H_TOT),
    .W   (DRAW_W)
  ) u_hcount (
    .clk        (vga_clk),
    .reset_n    (reset_n),
    .en         (1'b1),
    .count      (DrawX),
    .count_next (hc_next),
    .wrap       (h_wrap)
  );

  vga_mod_counter #(
    .MOD (V_TOT),
    .W   (DRAW_W)
  ) u_vcount (
    .clk        (vga_clk),
    .reset_n    (reset_n),
    .en         (h_wrap),
    .count      (DrawY),
    .count_next (vc_next),
    .wrap       (v_wrap)
  );

  // Decode the look-ahead position so every flag lines up with DrawX/DrawY.
  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      blank       <= 1'b1;
      hs          <= 1'b1;
      vs          <= 1'b1;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_count <= '0;
    end else begin
      blank       <= (int'(hc_next) < H_VISIBLE) && (int'(vc_next) < V_VISIBLE);
      hs          <= !((int'(hc_next) >= HS_BEGIN) && (int'(hc_next) < HS_END));
      vs          <= !((int'(vc_next) >= VS_BEGIN) && (int'(vc_next) < VS_END));
      line_start  <= (hc_next == '0);
      frame_start <= (hc_next == '0) && (vc_next == '0);
      if (v_wrap) begin
        frame_count <= frame_count + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire
